// File: rtl/in_xif.sv
// in_xif: shared CORE-V-XIF types plus issue-queue entry and FP decode constants.
package in_xif;
    localparam int X_ID_WIDTH  = 4;
    localparam int X_NUM_RS    = 2;
    localparam int X_RFR_WIDTH = 32;

    typedef struct packed {
        logic [31:0]                                 instr;
        logic [1:0]                                  mode;
        logic [X_ID_WIDTH-1:0]                       id;
        logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]        rs;
        logic [X_NUM_RS-1:0]                         rs_valid;
        logic [5:0]                                  ecs;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic dualwrite;
        logic dualread;
        logic loadstore;
        logic ecswrite;
        logic exc;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [31:0]                          instr;
        logic [X_ID_WIDTH-1:0]                id;
        logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
        logic                                 valid;
        logic                                 committed;
        logic                                 killed;
    } iq_entry_t;

    localparam logic [6:0] OPC_OP_FP   = 7'b1010011;
    localparam logic [6:0] OPC_FMADD   = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB   = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB  = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD  = 7'b1001111;
    localparam logic [6:0] OPC_FLW     = 7'b0000111;
    localparam logic [6:0] OPC_FSW     = 7'b0100111;
    localparam logic [6:0] F7_FMV_X_W  = 7'b1110000;
    localparam logic [6:0] F7_FCVT_W_S = 7'b1100000;
    localparam logic [6:0] F7_FCMP     = 7'b1010000;
    localparam logic [6:0] F7_FMV_W_X  = 7'b1111000;
    localparam logic [6:0] F7_FCVT_S_W = 7'b1101000;
endpackage

// File: rtl/xif_issue_queue_if.sv
// xif_issue_queue_if: issue, commit and execute channels between core, queue and FPU.
`ifndef QUEUE_DEPTH
`define QUEUE_DEPTH 4
`endif
interface xif_issue_queue_if #(parameter int QUEUE_DEPTH = `QUEUE_DEPTH);
    import in_xif::*;
    logic                                 issue_valid;
    logic                                 issue_ready;
    x_issue_req_t                         issue_req;
    x_issue_resp_t                        issue_resp;
    logic                                 commit_valid;
    x_commit_t                            commit;
    logic                                 exe_valid;
    logic                                 exe_ready;
    logic [31:0]                          exe_instr;
    logic [X_ID_WIDTH-1:0]                exe_id;
    logic [X_NUM_RS*X_RFR_WIDTH-1:0]      exe_rs;
    logic [$clog2(QUEUE_DEPTH+1)-1:0]     occupancy;

    modport master (
        output issue_valid, issue_req, commit_valid, commit, exe_ready,
        input  issue_ready, issue_resp, exe_valid, exe_instr, exe_id, exe_rs, occupancy
    );
    modport slave (
        input  issue_valid, issue_req, commit_valid, commit, exe_ready,
        output issue_ready, issue_resp, exe_valid, exe_instr, exe_id, exe_rs, occupancy
    );
endinterface

// File: rtl/xif_issue_decode.sv
// xif_issue_decode: combinational FP instruction decode into the XIF issue response.
module xif_issue_decode
    import in_xif::*;
(
    input  logic [31:0]   i_instr,
    output x_issue_resp_t o_resp,
    output logic          o_needs_rs0
);
    logic [6:0] w_opc, w_f7;
    logic       w_op_fp, w_fma, w_ls;

    always_comb begin
        w_opc   = i_instr[6:0];
        w_f7    = i_instr[31:25];
        w_op_fp = w_opc == OPC_OP_FP;
        w_fma   = w_opc == OPC_FMADD || w_opc == OPC_FMSUB || w_opc == OPC_FNMSUB || w_opc == OPC_FNMADD;
        w_ls    = w_opc == OPC_FLW || w_opc == OPC_FSW;
        o_resp           = '0;
        o_resp.accept    = w_op_fp || w_fma || w_ls;
        o_resp.loadstore = w_ls;
        o_resp.exc       = w_ls;
        o_resp.writeback = w_op_fp && (w_f7 == F7_FMV_X_W || w_f7 == F7_FCVT_W_S || w_f7 == F7_FCMP);
        o_needs_rs0      = w_ls || (w_op_fp && (w_f7 == F7_FMV_W_X || w_f7 == F7_FCVT_S_W));
    end
endmodule

// File: rtl/xif_issue_queue.sv
// xif_issue_queue: in-order issue buffer holding instructions until commit/kill, then feeding the FPU.
// Define XIF_ISSUE_BYPASS_EN for zero-latency dispatch of same-cycle committed issues into an empty queue.
`ifndef QUEUE_DEPTH
`define QUEUE_DEPTH 4
`endif
module xif_issue_queue
    import in_xif::*;
#(
    parameter int QUEUE_DEPTH = `QUEUE_DEPTH
) (
    input logic              clk,
    input logic              rst,
    xif_issue_queue_if.slave xif
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    iq_entry_t               r_q [QUEUE_DEPTH];
    logic [PW-1:0]           r_head, r_tail;
    logic [CW-1:0]           r_count;
    x_issue_resp_t           w_resp;
    iq_entry_t               w_head, w_new;
    logic [QUEUE_DEPTH-1:0]  w_hit;
    logic                    w_needs_rs0, w_full, w_head_exe, w_pop, w_fire, w_new_hit, w_bypass, w_enq;

    xif_issue_decode u_dec (
        .i_instr    (xif.issue_req.instr),
        .o_resp     (w_resp),
        .o_needs_rs0(w_needs_rs0)
    );

    always_comb begin
        w_head     = r_q[r_head];
        w_full     = r_count == CW'(QUEUE_DEPTH);
        w_head_exe = w_head.valid && w_head.committed && !w_head.killed;
        w_pop      = w_head.valid && (w_head.killed || (w_head_exe && xif.exe_ready));
        // a killed head frees its slot this cycle regardless of exe_ready, so a full queue may still accept
        xif.issue_ready = !w_resp.accept || (!rst && (!w_full || (w_head.valid && w_head.killed))
                          && (xif.issue_req.rs_valid[0] || !w_needs_rs0));
        xif.issue_resp  = w_resp;
        w_fire    = xif.issue_valid && xif.issue_ready && w_resp.accept;
        w_new_hit = xif.commit_valid && xif.commit.id == xif.issue_req.id;
`ifdef XIF_ISSUE_BYPASS_EN
        w_bypass  = w_fire && r_count == '0 && w_new_hit && !xif.commit.commit_kill && xif.exe_ready;
`else
        w_bypass  = 1'b0;
`endif
        w_enq     = w_fire && !w_bypass;
        w_new     = '{instr: xif.issue_req.instr, id: xif.issue_req.id, rs: xif.issue_req.rs, valid: 1'b1,
                      committed: w_new_hit, killed: w_new_hit && xif.commit.commit_kill};
        w_hit     = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++)
            w_hit[i] = xif.commit_valid && r_q[i].valid && !r_q[i].committed && r_q[i].id == xif.commit.id;
        xif.exe_valid = w_head_exe || w_bypass;
        xif.exe_instr = w_bypass ? xif.issue_req.instr : w_head_exe ? w_head.instr : '0;
        xif.exe_id    = w_bypass ? xif.issue_req.id : w_head_exe ? w_head.id : '0;
        xif.exe_rs    = w_bypass ? xif.issue_req.rs : w_head_exe ? w_head.rs : '0;
        xif.occupancy = r_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) r_q[i] <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++)
                if (w_hit[i]) begin
                    r_q[i].committed <= 1'b1;
                    r_q[i].killed    <= xif.commit.commit_kill;
                end
            if (w_pop) begin
                r_q[r_head].valid <= 1'b0;
                r_head            <= r_head + 1'b1;
            end
            // enqueue after pop so a full-queue refill of the freed head slot wins
            if (w_enq) begin
                r_q[r_tail] <= w_new;
                r_tail      <= r_tail + 1'b1;
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_xif_issue_queue.sv
// tb_xif_issue_queue: scoreboard bench for xif_issue_queue (bypass-aware via XIF_ISSUE_BYPASS_EN).
module tb_xif_issue_queue;
    import in_xif::*;

`ifdef XIF_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] FADD   = 32'h00208053;
    localparam logic [31:0] ADD    = 32'h00000033;
    localparam logic [31:0] FLW    = 32'h00002007;
    localparam logic [31:0] FCLASS = 32'hE0001053;
    localparam logic [31:0] FMVWX  = 32'hF0000053;

    typedef struct {
        logic [X_ID_WIDTH-1:0]           id;
        logic [31:0]                     instr;
        logic [X_NUM_RS*X_RFR_WIDTH-1:0] rs;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    sb_t  sb[$];
    sb_t  m_e;

    always #5 clk = ~clk;

    xif_issue_queue_if #(.QUEUE_DEPTH(4)) xif ();
    xif_issue_queue #(.QUEUE_DEPTH(4)) dut (.clk(clk), .rst(rst), .xif(xif));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [X_ID_WIDTH-1:0] id, input logic [31:0] instr, input logic [1:0] rsv);
        xif.issue_req          = '0;
        xif.issue_req.instr    = instr;
        xif.issue_req.id       = id;
        xif.issue_req.rs       = {$urandom, $urandom};
        xif.issue_req.rs_valid = rsv;
    endtask

    task automatic do_issue(input logic [X_ID_WIDTH-1:0] id, input logic [31:0] instr, input bit cmt, input bit exp_exe);
        int n = 0;
        set_req(id, instr, 2'b11);
        xif.issue_valid        = 1'b1;
        xif.commit_valid       = cmt;
        xif.commit.id          = id;
        xif.commit.commit_kill = 1'b0;
        while (!xif.issue_ready && n < 20) begin
            step();
            n++;
        end
        chk("issue_ready", xif.issue_ready, 1);
        if (exp_exe) sb.push_back('{id, instr, xif.issue_req.rs});
        step();
        xif.issue_valid  = 1'b0;
        xif.commit_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [X_ID_WIDTH-1:0] id, input bit kill);
        xif.commit_valid       = 1'b1;
        xif.commit.id          = id;
        xif.commit.commit_kill = kill;
        step();
        xif.commit_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (xif.exe_valid && xif.exe_ready) begin
            if (sb.size() == 0) chk("exe_spurious_id", xif.exe_id, 'hff);
            else begin
                m_e = sb.pop_front();
                chk("exe_id", xif.exe_id, m_e.id);
                chk("exe_instr", xif.exe_instr, m_e.instr);
                chk("exe_rs", xif.exe_rs, m_e.rs);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        xif.issue_valid  = 1'b0;
        xif.issue_req    = '0;
        xif.commit_valid = 1'b0;
        xif.commit       = '0;
        xif.exe_ready    = 1'b1;
        set_req(0, FADD, 2'b11);
        #1;
        chk("rst_occ", xif.occupancy, 0);
        chk("rst_exe_valid", xif.exe_valid, 0);
        chk("rst_exe_id", xif.exe_id, 0);
        chk("rst_ready_acc", xif.issue_ready, 0);
        set_req(0, ADD, 2'b11);
        #1;
        chk("rst_ready_rej", xif.issue_ready, 1);
        step();
        step();
        rst = 1'b0;

        // same-cycle issue and commit into an empty queue
        set_req(3, FADD, 2'b11);
        xif.issue_valid        = 1'b1;
        xif.commit_valid       = 1'b1;
        xif.commit.id          = 3;
        xif.commit.commit_kill = 1'b0;
        sb.push_back('{3, FADD, xif.issue_req.rs});
        #1;
        chk("t1_exe_now", xif.exe_valid, BYP);
        step();
        xif.issue_valid  = 1'b0;
        xif.commit_valid = 1'b0;
        #1;
        chk("t1_exe_next", xif.exe_valid, !BYP);
        chk("t1_id", xif.exe_valid ? xif.exe_id : 0, BYP ? 0 : 3);
        step();
        chk("t1_occ", xif.occupancy, 0);

        // rejected instruction
        set_req(1, ADD, 2'b11);
        xif.issue_valid = 1'b1;
        #1;
        chk("rej_accept", xif.issue_resp.accept, 0);
        chk("rej_ready", xif.issue_ready, 1);
        step();
        xif.issue_valid = 1'b0;
        chk("rej_occ", xif.occupancy, 0);

        // fill uncommitted, then commit out of order while the FPU stalls
        xif.exe_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_issue(X_ID_WIDTH'(i), FADD | (32'(i) << 7), 1'b0, 1'b1);
        chk("full_occ", xif.occupancy, 4);
        set_req(9, FADD, 2'b11);
        xif.issue_valid = 1'b1;
        #1;
        chk("full_ready", xif.issue_ready, 0);
        xif.issue_valid = 1'b0;
        do_commit(2, 1'b0);
        chk("ooo_stall", xif.exe_valid, 0);
        do_commit(0, 1'b0);
        chk("ooo_head_valid", xif.exe_valid, 1);
        chk("ooo_head_id", xif.exe_id, 0);
        do_commit(1, 1'b0);
        do_commit(3, 1'b0);
        chk("hold_valid", xif.exe_valid, 1);
        chk("hold_id", xif.exe_id, 0);
        chk("hold_instr", xif.exe_instr, FADD);
        xif.exe_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("ooo_occ", xif.occupancy, 0);
        chk("ooo_sb_empty", sb.size(), 0);

        // kill drain
        do_issue(5, FADD | 32'h0280, 1'b0, 1'b1);
        do_issue(6, FADD | 32'h0300, 1'b0, 1'b0);
        do_issue(7, FADD | 32'h0380, 1'b0, 1'b1);
        do_commit(6, 1'b1);
        chk("kill_stall", xif.exe_valid, 0);
        do_commit(5, 1'b0);
        chk("kill_h5", xif.exe_valid ? xif.exe_id : 4'hf, 5);
        do_commit(7, 1'b0);
        chk("kill_drop6", xif.exe_valid, 0);
        step();
        chk("kill_h7", xif.exe_valid ? xif.exe_id : 4'hf, 7);
        step();
        chk("kill_occ", xif.occupancy, 0);

        // operand wait and decode fields
        set_req(4, FMVWX, 2'b00);
        #1;
        chk("fmvwx_ready", xif.issue_ready, 0);
        set_req(4, FCLASS, 2'b00);
        #1;
        chk("fclass_wb", xif.issue_resp.writeback, 1);
        chk("fclass_ready", xif.issue_ready, 1);
        set_req(4, FLW, 2'b00);
        xif.issue_valid = 1'b1;
        #1;
        chk("flw_ready0", xif.issue_ready, 0);
        chk("flw_accept", xif.issue_resp.accept, 1);
        chk("flw_ls", xif.issue_resp.loadstore, 1);
        chk("flw_exc", xif.issue_resp.exc, 1);
        chk("flw_wb", xif.issue_resp.writeback, 0);
        step();
        step();
        chk("flw_wait_ready", xif.issue_ready, 0);
        chk("flw_wait_occ", xif.occupancy, 0);
        xif.issue_req.rs_valid = 2'b01;
        #1;
        chk("flw_ready1", xif.issue_ready, 1);
        sb.push_back('{4, FLW, xif.issue_req.rs});
        step();
        xif.issue_valid = 1'b0;
        chk("flw_occ", xif.occupancy, 1);
        do_commit(4, 1'b0);
        step();
        chk("flw_done_occ", xif.occupancy, 0);

        // back-to-back issue with same-cycle commit
        for (int i = 0; i < 8; i++)
            do_issue(X_ID_WIDTH'($urandom), FADD | ($urandom & 32'h01FFFF80), 1'b1, 1'b1);
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_sb", sb.size(), 0);

        // reset mid-flight with committed entries waiting on a stalled FPU
        xif.exe_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_issue(X_ID_WIDTH'(i + 1), FADD, 1'b1, 1'b0);
        chk("mid_occ", xif.occupancy, 3);
        chk("mid_exe_valid", xif.exe_valid, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_occ", xif.occupancy, 0);
        chk("mid_rst_valid", xif.exe_valid, 0);
        chk("mid_rst_id", xif.exe_id, 0);
        step();
        rst = 1'b0;
        xif.exe_ready = 1'b1;
        step();
        chk("post_rst_occ", xif.occupancy, 0);
        chk("post_rst_valid", xif.exe_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/xif_issue_queue.md
# xif_issue_queue

Coprocessor-side issue/commit stage of rvfpm, directly behind the CORE-V-XIF issue and commit channels. It decodes each offered instruction, answers the issue handshake, and buffers accepted instructions in order. It holds them until the core commits or kills them. Committed instructions are released in order to the FPU execute pipeline over a valid/ready channel; killed ones are discarded.

## Interface
- `QUEUE_DEPTH`, default `QUEUE_DEPTH` define (4); number of entries; power of two, ≥2.
- `X_ID_WIDTH`, `X_NUM_RS`, `X_RFR_WIDTH`, defaults from `in_xif`; widths of id and operand fields.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `issue_valid` in 1: core offers an instruction.
- `issue_ready` out 1: handshake completes when `issue_valid && issue_ready`.
- `issue_req` in `x_issue_req_t`: instr, mode, id, rs, rs_valid, ecs.
- `issue_resp` out `x_issue_resp_t`: combinational decode, valid while `issue_valid`.
- `commit_valid` in 1: commit strobe.
- `commit` in `x_commit_t`: id, commit_kill.
- `exe_valid` out 1: head entry is committed and ready to execute.
- `exe_ready` in 1: FPU pipeline accepts.
- `exe_instr` out 32: instruction word of the head entry.
- `exe_id` out `X_ID_WIDTH`: id of the head entry.
- `exe_rs` out `X_NUM_RS*X_RFR_WIDTH`: captured source operands.
- `occupancy` out `$clog2(QUEUE_DEPTH+1)`: number of valid entries.

## Operation
- **Decode.** `accept` is 1 for these opcodes: OP-FP 1010011, FMADD/FMSUB/FNMSUB/FNMADD 1000011/1000111/1001011/1001111, FLW 0000111, FSW 0100111. All other opcodes give `accept` 0.
- **Response fields.** `loadstore` is 1 for FLW/FSW. `writeback` is 1 for OP-FP with funct7 ∈ {1110000 FMV.X.W/FCLASS, 1100000 FCVT.W.S, 1010000 compare}. `exc` is 1 for FLW/FSW. `dualwrite`, `dualread` and `ecswrite` are always 0.
- **Operand requirement.** `rs_valid[0]` is required for FLW, FSW, funct7 1111000 (FMV.W.X) and funct7 1101000 (FCVT.S.W). No other instruction requires it.
- **issue_ready.**
  - For a rejected instruction: 1.
  - For an accepted instruction: `!full && (rs_valid[0] || !needs_rs0)`.
- **Enqueue.** An accepted handshake writes an entry {instr, id, rs, committed=0, killed=0} at the tail pointer.
- **Commit.** `commit_valid` compares `commit.id` against every valid, not-yet-committed entry.
  - On a match, set `committed`, and also set `killed` if `commit_kill`.
  - If there is no match, the commit is ignored.
  - If the commit id equals an instruction being enqueued in the same cycle, the new entry is written with the commit applied.
- **Head processing, one action per cycle.**
  - Head valid, committed and not killed: `exe_valid`=1. Pop when `exe_ready`.
  - Head killed: pop silently, with `exe_valid`=0.
  - Head uncommitted: stall.
- **Pointers.** Head and tail are `$clog2(QUEUE_DEPTH)` bits and wrap modulo `QUEUE_DEPTH`. The count is tracked separately.
- **Full and empty.** Full when the count equals `QUEUE_DEPTH`; empty when the count is 0.
- **Enqueue and pop together.** Simultaneous enqueue and pop leaves the count unchanged. This is allowed when full only if the pop is known combinationally; `issue_ready` does not depend on `exe_ready`.

## Timing
- **Latency.** An instruction issued and committed in cycle N, into an empty queue, gives `exe_valid` in N+1.
- **Commit after issue.** A commit in cycle M > N gives `exe_valid` in M+1 if the entry is at the head.
- **Kill drain.** A killed head is dropped in the cycle after its kill, at one entry per cycle.
- **Output stability.** `exe_*` outputs stay stable while `exe_valid && !exe_ready`.
- **Reset values.** All pointers, the count, and every entry's valid/committed/killed flags go to 0 immediately on reset. Outputs during reset:
  - `issue_ready`: 1 for rejected instructions, 0 otherwise.
  - `exe_valid`, `occupancy`, `exe_instr`, `exe_id`, `exe_rs`: 0.
- **Reset mid-operation.** All entries are discarded, with no `exe_valid` pulse.

## Configuration
- **`XIF_ISSUE_BYPASS_EN` defined:**
  - Bypass condition: the queue is empty, an accepted instruction handshakes, `commit_valid` with a matching id and `commit_kill`=0 arrives in the same cycle, and `exe_ready`=1.
  - Effect: `exe_*` is driven straight from `issue_req` with `exe_valid`=1 in that same cycle (zero latency), and nothing is enqueued.
- **Not defined:** every instruction passes through the queue, with minimum latency 1.

## Structure
- **Added to the shared package `in_xif`:**
  - `iq_entry_t`: instr, id, rs, valid, committed, killed.
  - Opcode/funct7 localparams for the decode.
- **Sub-module `xif_issue_decode`:** purely combinational; maps instr to `x_issue_resp_t` plus `needs_rs0`.
- **Queue storage:** an `iq_entry_t` array inside `xif_issue_queue`.

## Test plan
- **Issue/commit, same cycle.** Issue FADD.S (0x00208053, id 3) with commit id 3, kill 0, same cycle, `exe_ready`=1 → `exe_valid` next cycle with `exe_id`=3, `occupancy` back to 0.
- **Reject.** Issue ADD (0x00000033) → `accept`=0, `issue_ready`=1, no enqueue, `occupancy` stays 0.
- **Full, out-of-order commits.** Fill 4 entries (ids 0–3) uncommitted → `issue_ready`=0. Commit ids 2, 0, 1, 3 → dispatch order 0, 1, 2, 3.
- **Kill drain.** Issue ids 5, 6, 7; kill 6, commit 5 and 7 → exe sees 5 then 7, and 6 never appears.
- **Operand wait.** FLW with `rs_valid[0]`=0 → `issue_ready`=0 until `rs_valid` rises, then accept with `loadstore`=1 and `exc`=1.
- **Reset mid-flight.** Assert `rst` with 3 entries present → `occupancy`=0 and `exe_valid`=0 immediately. With bypass enabled, an empty-queue same-cycle commit gives `exe_valid` in the issue cycle.
